// File: rtl/fu_mem_responder.sv
// Memory-side responder: round-robin arbitration of FU memory requests onto the single Dmem bus.
// Optional build macro FU_MEM_STORE_EARLY_ACK_EN: stores ack on bus acceptance instead of tag return.
//
// state | meaning
// IDLE  | pick the next eligible requester, latch its packet
// ISSUE | drive the latched request on the bus until the memory accepts it
// WAIT  | wait for the returning tag that matches the accepted one
// ACK   | one-cycle mem_ack to the owner, advance the round-robin pointer

`ifndef XLEN
`define XLEN 32
`endif

module fu_mem_responder #(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 4,
    // packet layout: [1:0] command, [3:2] size, [XLEN+3:4] addr, [2*XLEN+3:XLEN+4] data
    localparam int PKT_W  = 4 + 2 * `XLEN
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       mem_req,
    input  logic [NUM_REQ*PKT_W-1:0] fu_mem_packet,
    output logic [NUM_REQ-1:0]       mem_ack,
    output logic [`XLEN-1:0]         mem_rdata,
    output logic [1:0]               proc2Dmem_command,
    output logic [`XLEN-1:0]         proc2Dmem_addr,
    output logic [63:0]              proc2Dmem_data,
    output logic [1:0]               proc2Dmem_size,
    input  logic [TAG_W-1:0]         Dmem2proc_response,
    input  logic [63:0]              Dmem2proc_data,
    input  logic [TAG_W-1:0]         Dmem2proc_tag,
    output logic                     busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] ACK   = 2'd3;

    logic [1:0]         state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   owner;
    logic [TAG_W-1:0]   tag_q;
    logic [NUM_REQ-1:0] cooldown;
    logic [1:0]         lat_cmd;
    logic               lat_addr2;

    logic [NUM_REQ-1:0] eligible;
    logic               grant_vld;
    logic [IDX_W-1:0]   grant_idx;
    logic [PKT_W-1:0]   sel_pkt;
    logic [1:0]         sel_cmd;
    logic [1:0]         sel_size;
    logic [`XLEN-1:0]   sel_addr;
    logic [`XLEN-1:0]   sel_data;
    logic [NUM_REQ-1:0] owner_onehot;
    logic [IDX_W-1:0]   rr_next;

    always_comb begin : grant_sel
        int idx;
        eligible  = mem_req & ~cooldown;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!grant_vld && eligible[idx]) begin
                grant_vld = 1'b1;
                grant_idx = IDX_W'(idx);
            end
        end
    end

    assign sel_pkt  = fu_mem_packet[grant_idx*PKT_W +: PKT_W];
    assign sel_cmd  = sel_pkt[1:0];
    assign sel_size = sel_pkt[3:2];
    assign sel_addr = sel_pkt[4 +: `XLEN];
    assign sel_data = sel_pkt[4 + `XLEN +: `XLEN];

    assign owner_onehot = NUM_REQ'(1) << owner;
    assign rr_next      = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);
    assign busy         = (state != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            rr_ptr            <= '0;
            owner             <= '0;
            tag_q             <= '0;
            cooldown          <= '0;
            lat_cmd           <= BUS_NONE;
            lat_addr2         <= 1'b0;
            mem_ack           <= '0;
            mem_rdata         <= '0;
            proc2Dmem_command <= BUS_NONE;
            proc2Dmem_addr    <= '0;
            proc2Dmem_data    <= '0;
            proc2Dmem_size    <= '0;
        end else begin
            mem_ack   <= '0;
            mem_rdata <= '0;
            case (state)
                IDLE: begin
                    // cooldown only has to cover the single IDLE cycle after an ack
                    cooldown <= '0;
                    if (grant_vld) begin
                        owner             <= grant_idx;
                        lat_cmd           <= sel_cmd;
                        lat_addr2         <= sel_addr[2];
                        proc2Dmem_command <= sel_cmd;
                        proc2Dmem_addr    <= sel_addr;
                        proc2Dmem_size    <= sel_size;
                        proc2Dmem_data    <= sel_addr[2] ? {sel_data, 32'h0} : {32'h0, sel_data};
                        state             <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (Dmem2proc_response != '0) begin
                        tag_q             <= Dmem2proc_response;
                        proc2Dmem_command <= BUS_NONE;
                        proc2Dmem_addr    <= '0;
                        proc2Dmem_data    <= '0;
                        proc2Dmem_size    <= '0;
`ifdef FU_MEM_STORE_EARLY_ACK_EN
                        if (lat_cmd == BUS_STORE) begin
                            mem_ack <= owner_onehot;
                            state   <= ACK;
                        end else begin
                            state   <= WAIT;
                        end
`else
                        state             <= WAIT;
`endif
                    end
                end
                WAIT: begin
                    if (Dmem2proc_tag == tag_q) begin
                        mem_ack <= owner_onehot;
                        if (lat_cmd == BUS_LOAD)
                            mem_rdata <= lat_addr2 ? Dmem2proc_data[63:32] : Dmem2proc_data[31:0];
                        state   <= ACK;
                    end
                end
                ACK: begin
                    rr_ptr   <= rr_next;
                    cooldown <= owner_onehot;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fu_mem_responder.sv
// Directed self-checking bench for fu_mem_responder (NUM_REQ=2, TAG_W=4).
// Honours FU_MEM_STORE_EARLY_ACK_EN when the build defines it.
module tb_fu_mem_responder;

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    logic         clock = 1'b0;
    logic         reset;
    logic [1:0]   mem_req;
    logic [67:0]  pkt0, pkt1;
    logic [135:0] fu_mem_packet;
    logic [1:0]   mem_ack;
    logic [31:0]  mem_rdata;
    logic [1:0]   proc2Dmem_command;
    logic [31:0]  proc2Dmem_addr;
    logic [63:0]  proc2Dmem_data;
    logic [1:0]   proc2Dmem_size;
    logic [3:0]   Dmem2proc_response;
    logic [63:0]  Dmem2proc_data;
    logic [3:0]   Dmem2proc_tag;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    assign fu_mem_packet = {pkt1, pkt0};

    fu_mem_responder #(.NUM_REQ(2), .TAG_W(4)) dut (
        .clock              (clock),
        .reset              (reset),
        .mem_req            (mem_req),
        .fu_mem_packet      (fu_mem_packet),
        .mem_ack            (mem_ack),
        .mem_rdata          (mem_rdata),
        .proc2Dmem_command  (proc2Dmem_command),
        .proc2Dmem_addr     (proc2Dmem_addr),
        .proc2Dmem_data     (proc2Dmem_data),
        .proc2Dmem_size     (proc2Dmem_size),
        .Dmem2proc_response (Dmem2proc_response),
        .Dmem2proc_data     (Dmem2proc_data),
        .Dmem2proc_tag      (Dmem2proc_tag),
        .busy               (busy)
    );

    always #5 clock = ~clock;

    function automatic logic [67:0] mk(input logic [1:0] cmd, input logic [31:0] addr,
                                       input logic [31:0] data, input logic [1:0] size);
        return {data, addr, size, cmd};
    endfunction

    task automatic test_reset;
        n_checks++; if (mem_ack !== 2'b00) begin n_fail++; $display("FAIL reset_ack: actual %b required 00", mem_ack); end
        n_checks++; if (mem_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: actual %h required 0", mem_rdata); end
        n_checks++; if (proc2Dmem_command !== BUS_NONE) begin n_fail++; $display("FAIL reset_cmd: actual %0d required 0", proc2Dmem_command); end
        n_checks++; if (proc2Dmem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: actual %h required 0", proc2Dmem_addr); end
        n_checks++; if (proc2Dmem_data !== 64'h0) begin n_fail++; $display("FAIL reset_data: actual %h required 0", proc2Dmem_data); end
        n_checks++; if (proc2Dmem_size !== 2'd0) begin n_fail++; $display("FAIL reset_size: actual %0d required 0", proc2Dmem_size); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: actual %b required 0", busy); end
    endtask

    task automatic test_single_load;
        pkt0 = mk(BUS_LOAD, 32'h104, 32'h0, 2'd2);
        mem_req = 2'b01;
        @(negedge clock);
        n_checks++; if (proc2Dmem_command !== BUS_LOAD) begin n_fail++; $display("FAIL load_cmd: actual %0d required 1", proc2Dmem_command); end
        n_checks++; if (proc2Dmem_addr !== 32'h104) begin n_fail++; $display("FAIL load_addr: actual %h required 104", proc2Dmem_addr); end
        n_checks++; if (proc2Dmem_size !== 2'd2) begin n_fail++; $display("FAIL load_size: actual %0d required 2", proc2Dmem_size); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL load_busy: actual %b required 1", busy); end
        Dmem2proc_response = 4'd3;
        @(negedge clock);
        Dmem2proc_response = 4'd0;
        n_checks++; if (proc2Dmem_command !== BUS_NONE) begin n_fail++; $display("FAIL load_cmd_none: actual %0d required 0", proc2Dmem_command); end
        @(negedge clock);
        n_checks++; if (mem_ack !== 2'b00) begin n_fail++; $display("FAIL load_early_ack: actual %b required 00", mem_ack); end
        Dmem2proc_tag  = 4'd3;
        Dmem2proc_data = 64'hAAAA_BBBB_1111_2222;
        @(negedge clock);
        n_checks++; if (mem_ack !== 2'b01) begin n_fail++; $display("FAIL load_ack: actual %b required 01", mem_ack); end
        n_checks++; if (mem_rdata !== 32'hAAAABBBB) begin n_fail++; $display("FAIL load_rdata: actual %h required aaaabbbb", mem_rdata); end
        Dmem2proc_tag  = 4'd0;
        Dmem2proc_data = 64'h0;
        @(negedge clock);
        n_checks++; if (mem_ack !== 2'b00) begin n_fail++; $display("FAIL load_ack_pulse: actual %b required 00", mem_ack); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL load_busy_after: actual %b required 0", busy); end
        @(negedge clock);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL load_cooldown: actual busy %b required 0", busy); end
        mem_req = 2'b00;
        @(negedge clock);
    endtask

    task automatic test_store_retry;
        pkt1 = mk(BUS_STORE, 32'h200, 32'hDEADBEEF, 2'd2);
        mem_req = 2'b10;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            n_checks++; if (proc2Dmem_command !== BUS_STORE) begin n_fail++; $display("FAIL store_hold_%0d: actual %0d required 2", k, proc2Dmem_command); end
        end
        n_checks++; if (proc2Dmem_data !== 64'h00000000_DEADBEEF) begin n_fail++; $display("FAIL store_data: actual %h required 00000000deadbeef", proc2Dmem_data); end
        n_checks++; if (proc2Dmem_addr !== 32'h200) begin n_fail++; $display("FAIL store_addr: actual %h required 200", proc2Dmem_addr); end
        @(negedge clock);
        n_checks++; if (proc2Dmem_command !== BUS_STORE) begin n_fail++; $display("FAIL store_hold_4: actual %0d required 2", proc2Dmem_command); end
        Dmem2proc_response = 4'd5;
        @(negedge clock);
        Dmem2proc_response = 4'd0;
        n_checks++; if (proc2Dmem_command !== BUS_NONE) begin n_fail++; $display("FAIL store_cmd_none: actual %0d required 0", proc2Dmem_command); end
`ifdef FU_MEM_STORE_EARLY_ACK_EN
        n_checks++; if (mem_ack !== 2'b10) begin n_fail++; $display("FAIL store_early_ack: actual %b required 10", mem_ack); end
        Dmem2proc_tag = 4'd5;
        @(negedge clock);
        n_checks++; if (mem_ack !== 2'b00) begin n_fail++; $display("FAIL store_tag_ignored: actual %b required 00", mem_ack); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL store_busy_after: actual %b required 0", busy); end
        Dmem2proc_tag = 4'd0;
        @(negedge clock);
        mem_req = 2'b00;
`else
        n_checks++; if (mem_ack !== 2'b00) begin n_fail++; $display("FAIL store_no_early_ack: actual %b required 00", mem_ack); end
        Dmem2proc_tag = 4'd5;
        @(negedge clock);
        n_checks++; if (mem_ack !== 2'b10) begin n_fail++; $display("FAIL store_ack: actual %b required 10", mem_ack); end
        n_checks++; if (mem_rdata !== 32'h0) begin n_fail++; $display("FAIL store_rdata: actual %h required 0", mem_rdata); end
        Dmem2proc_tag = 4'd0;
        @(negedge clock);
        mem_req = 2'b00;
        n_checks++; if (mem_ack !== 2'b00) begin n_fail++; $display("FAIL store_ack_pulse: actual %b required 00", mem_ack); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL store_busy_after: actual %b required 0", busy); end
`endif
        @(negedge clock);
    endtask

    task automatic test_contention;
        pkt0 = mk(BUS_LOAD, 32'h10, 32'h0, 2'd2);
        pkt1 = mk(BUS_STORE, 32'h20, 32'h12345678, 2'd2);
        mem_req = 2'b11;
        @(negedge clock);
        n_checks++; if (proc2Dmem_addr !== 32'h10) begin n_fail++; $display("FAIL cont_first_addr: actual %h required 10", proc2Dmem_addr); end
        n_checks++; if (proc2Dmem_command !== BUS_LOAD) begin n_fail++; $display("FAIL cont_first_cmd: actual %0d required 1", proc2Dmem_command); end
        Dmem2proc_response = 4'd1;
        @(negedge clock);
        Dmem2proc_response = 4'd0;
        Dmem2proc_tag  = 4'd1;
        Dmem2proc_data = 64'h0000_0000_5555_6666;
        @(negedge clock);
        n_checks++; if (mem_ack !== 2'b01) begin n_fail++; $display("FAIL cont_ack0: actual %b required 01", mem_ack); end
        n_checks++; if (mem_rdata !== 32'h55556666) begin n_fail++; $display("FAIL cont_rdata0: actual %h required 55556666", mem_rdata); end
        Dmem2proc_tag = 4'd0;
        @(negedge clock);
        @(negedge clock);
        n_checks++; if (proc2Dmem_addr !== 32'h20) begin n_fail++; $display("FAIL cont_second_addr: actual %h required 20", proc2Dmem_addr); end
        n_checks++; if (proc2Dmem_data !== 64'h00000000_12345678) begin n_fail++; $display("FAIL cont_second_data: actual %h required 0000000012345678", proc2Dmem_data); end
        pkt1 = mk(BUS_LOAD, 32'h99, 32'h0, 2'd0);
        pkt0 = mk(BUS_LOAD, 32'h34, 32'h0, 2'd2);
        @(negedge clock);
        n_checks++; if (proc2Dmem_addr !== 32'h20) begin n_fail++; $display("FAIL cont_latch_addr: actual %h required 20", proc2Dmem_addr); end
        n_checks++; if (proc2Dmem_command !== BUS_STORE) begin n_fail++; $display("FAIL cont_latch_cmd: actual %0d required 2", proc2Dmem_command); end
        Dmem2proc_response = 4'd2;
        @(negedge clock);
        Dmem2proc_response = 4'd0;
`ifndef FU_MEM_STORE_EARLY_ACK_EN
        Dmem2proc_tag = 4'd2;
        @(negedge clock);
        Dmem2proc_tag = 4'd0;
`endif
        n_checks++; if (mem_ack !== 2'b10) begin n_fail++; $display("FAIL cont_ack1: actual %b required 10", mem_ack); end
        mem_req = 2'b01;
        @(negedge clock);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cont_idle: actual busy %b required 0", busy); end
        @(negedge clock);
        n_checks++; if (proc2Dmem_addr !== 32'h34) begin n_fail++; $display("FAIL cont_third_addr: actual %h required 34", proc2Dmem_addr); end
        Dmem2proc_response = 4'd6;
        @(negedge clock);
        Dmem2proc_response = 4'd0;
        Dmem2proc_tag  = 4'd6;
        Dmem2proc_data = 64'h7777_8888_9999_AAAA;
        @(negedge clock);
        n_checks++; if (mem_ack !== 2'b01) begin n_fail++; $display("FAIL cont_ack0b: actual %b required 01", mem_ack); end
        n_checks++; if (mem_rdata !== 32'h77778888) begin n_fail++; $display("FAIL cont_rdata0b: actual %h required 77778888", mem_rdata); end
        Dmem2proc_tag = 4'd0;
        mem_req = 2'b00;
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic test_stray_tag;
        pkt1 = mk(BUS_LOAD, 32'h40, 32'h0, 2'd2);
        mem_req = 2'b10;
        @(negedge clock);
        Dmem2proc_response = 4'd7;
        @(negedge clock);
        Dmem2proc_response = 4'd0;
        Dmem2proc_tag  = 4'd2;
        Dmem2proc_data = 64'h1234_5678_CAFE_F00D;
        @(negedge clock);
        n_checks++; if (mem_ack !== 2'b00) begin n_fail++; $display("FAIL stray_no_ack: actual %b required 00", mem_ack); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stray_busy: actual %b required 1", busy); end
        Dmem2proc_tag = 4'd7;
        @(negedge clock);
        n_checks++; if (mem_ack !== 2'b10) begin n_fail++; $display("FAIL stray_ack: actual %b required 10", mem_ack); end
        n_checks++; if (mem_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL stray_rdata: actual %h required cafef00d", mem_rdata); end
        Dmem2proc_tag = 4'd0;
        mem_req = 2'b00;
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset_mid;
        pkt0 = mk(BUS_LOAD, 32'h8, 32'h0, 2'd2);
        mem_req = 2'b01;
        @(negedge clock);
        n_checks++; if (proc2Dmem_command !== BUS_LOAD) begin n_fail++; $display("FAIL rmid_cmd: actual %0d required 1", proc2Dmem_command); end
        Dmem2proc_response = 4'd9;
        @(negedge clock);
        Dmem2proc_response = 4'd0;
        mem_req = 2'b00;
        #2 reset = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: actual %b required 0", busy); end
        n_checks++; if (mem_ack !== 2'b00) begin n_fail++; $display("FAIL rmid_ack: actual %b required 00", mem_ack); end
        n_checks++; if (proc2Dmem_command !== BUS_NONE) begin n_fail++; $display("FAIL rmid_cmd_none: actual %0d required 0", proc2Dmem_command); end
        @(negedge clock);
        reset = 1'b1;
        Dmem2proc_tag  = 4'd9;
        Dmem2proc_data = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clock);
        n_checks++; if (mem_ack !== 2'b00) begin n_fail++; $display("FAIL rmid_late_tag: actual %b required 00", mem_ack); end
        n_checks++; if (mem_rdata !== 32'h0) begin n_fail++; $display("FAIL rmid_rdata: actual %h required 0", mem_rdata); end
        Dmem2proc_tag = 4'd0;
        @(negedge clock);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_idle: actual %b required 0", busy); end
    endtask

`ifdef FU_MEM_STORE_EARLY_ACK_EN
    task automatic test_early_ack;
        pkt1 = mk(BUS_STORE, 32'h44, 32'h0BADF00D, 2'd2);
        mem_req = 2'b10;
        @(negedge clock);
        n_checks++; if (proc2Dmem_data !== 64'h0BADF00D_00000000) begin n_fail++; $display("FAIL early_data: actual %h required 0badf00d00000000", proc2Dmem_data); end
        Dmem2proc_response = 4'd4;
        @(negedge clock);
        Dmem2proc_response = 4'd0;
        n_checks++; if (mem_ack !== 2'b10) begin n_fail++; $display("FAIL early_ack: actual %b required 10", mem_ack); end
        Dmem2proc_tag = 4'd4;
        @(negedge clock);
        mem_req = 2'b00;
        n_checks++; if (mem_ack !== 2'b00) begin n_fail++; $display("FAIL early_tag_ignored: actual %b required 00", mem_ack); end
        Dmem2proc_tag = 4'd0;
        @(negedge clock);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL early_idle: actual %b required 0", busy); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        mem_req = 2'b00;
        pkt0 = '0;
        pkt1 = '0;
        Dmem2proc_response = 4'd0;
        Dmem2proc_data = 64'h0;
        Dmem2proc_tag = 4'd0;
        repeat (2) @(negedge clock);
        test_reset;
        reset = 1'b1;
        @(negedge clock);
        test_single_load;
        test_store_retry;
        test_contention;
        test_stray_tag;
        test_reset_mid;
`ifdef FU_MEM_STORE_EARLY_ACK_EN
        test_early_ack;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fu_mem_responder.md
Name: fu_mem_responder

Overview:
- Memory-side responder for functional-unit data-memory requests. It sits between the load/store FUs and the single Dmem bus.
- Accepts level-held mem_req plus FU_MEM_PACKET from NUM_REQ requesters and arbitrates round-robin. Issues one transaction at a time on the proc2Dmem bus.
- Tracks the tagged memory response, returns a one-cycle mem_ack and load data to the owning FU.

Parameters:
- NUM_REQ, 2, number of FU requesters (index 0 = load FU, 1 = store FU by convention); ≥1.
- TAG_W, 4, width of memory response/data tags.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- mem_req  input  NUM_REQ  per-FU request, held high until the FU sees mem_ack.
- fu_mem_packet  input  NUM_REQ x FU_MEM_PACKET  per-FU command/addr/data/size.
- mem_ack  output  NUM_REQ  one-hot, one-cycle completion pulse.
- mem_rdata  output  `XLEN  load data; valid only in the mem_ack cycle.
- proc2Dmem_command  output  BUS_COMMAND  BUS_NONE/BUS_LOAD/BUS_STORE.
- proc2Dmem_addr  output  `XLEN  transaction address.
- proc2Dmem_data  output  64  store data.
- proc2Dmem_size  output  MEM_SIZE  access size.
- Dmem2proc_response  input  TAG_W  nonzero = request accepted with that tag; 0 = retry.
- Dmem2proc_data  input  64  returned data.
- Dmem2proc_tag  input  TAG_W  tag of returning data; 0 = none.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (reset==0, async) values:
  - state=IDLE, rr_ptr=0, owner=0, latched tag=0, cooldown mask=0.
  - mem_ack=0, mem_rdata=0, proc2Dmem_command=BUS_NONE, addr/data/size=0, busy=0.
- States: IDLE -> ISSUE -> WAIT -> ACK -> IDLE.
- IDLE:
  - Eligible requesters = mem_req & ~cooldown.
  - Grant the first eligible index at or after rr_ptr, wrapping modulo NUM_REQ.
  - Latch the granted packet and owner. Go to ISSUE the next cycle. No eligible requester: stay in IDLE.
- ISSUE:
  - Drive the bus from the latched packet (command taken from the packet). Outputs are registered and stable for the whole state.
  - Address: proc2Dmem_addr = addr with bits [1:0] kept.
  - Store data: placed at bits [63:32] if addr[2]=1, else [31:0]; the other half is 0.
  - Dmem2proc_response==0: hold the request (retry), no limit.
  - Dmem2proc_response nonzero: latch the tag, drive BUS_NONE from the next cycle, go to WAIT.
- WAIT:
  - Leave on Dmem2proc_tag == latched tag, going to ACK.
  - Load data = Dmem2proc_data[63:32] if addr[2]=1, else [31:0]. The word is not sign-extended or masked; the load FU does that.
  - Non-matching nonzero tags are ignored.
- ACK:
  - mem_ack[owner]=1 for exactly this cycle; mem_rdata is valid (0 for stores).
  - rr_ptr = owner+1, mod NUM_REQ.
  - Set cooldown[owner] for one cycle, because the FU drops mem_req one cycle after mem_ack. The owner therefore cannot be regranted in the IDLE cycle that follows. The cooldown bit clears after that IDLE cycle.
  - Go to IDLE.
- Latency:
  - Minimum grant-to-ack is 4 cycles: IDLE, ISSUE (response in the same cycle), WAIT (tag in the first cycle), ACK.
  - A tag arriving in the same cycle the response is accepted is not captured. The memory never returns a tag earlier than one cycle after the response.
- Arbitration:
  - Requests arriving while busy wait; there is no queue, since mem_req is level-held.
  - Simultaneous requests are served in round-robin order from rr_ptr.
  - A request withdrawn before grant is simply not granted. A request withdrawn after grant still completes and acks.
- Reset mid-transaction: everything returns to reset values immediately. An outstanding memory tag is abandoned and any later matching tag is ignored, because state is IDLE.
- Packet latch: the latched packet is immune to FU input changes after the grant.

Optional Feature:
- Macro: FU_MEM_STORE_EARLY_ACK_EN.
- Defined: a BUS_STORE transaction goes ISSUE -> ACK directly when Dmem2proc_response is nonzero, skipping WAIT. Minimum store latency is 3 cycles. The returning store tag is ignored.
- Undefined: stores wait for the tag match like loads.

Test Plan:
- Single load: req0 with BUS_LOAD, addr 0x104; response=3 on the first ISSUE cycle, tag=3 two cycles later with data 0xAAAA_BBBB_1111_2222 -> mem_ack[0] pulses once, mem_rdata=0xAAAABBBB, busy low the next cycle.
- Store with retry: req1 with BUS_STORE, addr 0x200, data 0xDEADBEEF; response=0 for 3 cycles, then 5 -> command held BUS_STORE for 4 cycles, proc2Dmem_data=0x00000000DEADBEEF, then BUS_NONE. Tag 5 -> mem_ack[1] pulse.
- Contention: req0 and req1 rise together with rr_ptr=0 -> req0 served first. req0 held one cycle past its ack -> no regrant, req1 granted next. Then a third request from req0 is served after req1.
- Stray tag: during WAIT with tag 7, inject tag 2 -> no ack. Tag 7 -> ack.
- Async reset asserted in WAIT -> all outputs zero immediately, with no clock edge needed. A later tag match -> no mem_ack.
- With FU_MEM_STORE_EARLY_ACK_EN: store with response=4 in the first ISSUE cycle -> mem_ack[1] on the next cycle, and a later tag 4 is ignored.
